// File: rtl/nes_pkg.sv
// Shared definitions for the NES core host command port: opcodes, loader states, command packing.
package nes_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = OP_W + DATA_W;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [OP_W-1:0] {
        OP_RESET_CPU = 8'd0,
        OP_START_CPU = 8'd1,
        OP_PAUSE_CPU = 8'd2,
        OP_WRITE_MEM = 8'd3
    } nes_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN
    } loader_state_e;

    typedef struct packed {
        nes_op_e           op;
        logic [DATA_W-1:0] data;
    } nes_cmd_t;

    // Pack an opcode and its data byte into the core's 16-bit writedata word.
    function automatic logic [WORD_W-1:0] pack_cmd(input nes_op_e op, input logic [DATA_W-1:0] data);
        nes_cmd_t cmd;
        cmd.op   = op;
        cmd.data = data;
        return cmd;
    endfunction

endpackage

// File: rtl/nes_loader.sv
// Turns a byte stream into RESET_CPU, WRITE_MEM per byte, START_CPU commands for the NES core host port.
module nes_loader
    import nes_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pause,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [WORD_W-1:0] m_writedata,
    output logic              busy,
    output logic              done
);

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_q;
    logic              xfer;

    // Next state, counters and the command word the core sees next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        base_d  = base_q;
        len_d   = len_q;
        wdata_d = pack_cmd(OP_PAUSE_CPU, DATA_W'(0));
        addr_d  = '0;
        write_d = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        xfer    = s_valid && ready_q;

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    state_d = ST_RESET;
                    cnt_d   = CNT_W'(RESET_CYCLES - 1);
                    base_d  = base_addr;
                    len_d   = length;
                    idx_d   = '0;
                end else if (state_q == ST_RUN && pause) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESET: begin
                if (cnt_q == '0) begin
                    if (len_q != '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    idx_d = idx_q + CNT_W'(1);
                    // Last beat's own cycle precedes the settle window, hence one extra count.
                    if (idx_q == len_q - CNT_W'(1)) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES);
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_RESET: wdata_d = pack_cmd(OP_RESET_CPU, DATA_W'(0));
            ST_LOAD:  ready_d = 1'b1;
            ST_RUN:   wdata_d = pack_cmd(OP_START_CPU, DATA_W'(0));
            default:  ;
        endcase

        if (state_q == ST_LOAD && xfer) begin
            wdata_d = pack_cmd(OP_WRITE_MEM, s_data);
            write_d = 1'b1;
            addr_d  = base_q + idx_q;
        end

        busy_d = (state_d == ST_RESET) || (state_d == ST_LOAD) || (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            wdata_q <= pack_cmd(OP_PAUSE_CPU, DATA_W'(0));
            addr_q  <= '0;
            write_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= 1'b1;
        end
    end

    assign s_ready      = ready_q;
    assign m_chipselect = cs_q;
    assign m_write      = write_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_nes_loader.sv
// Directed bench for nes_loader: timeline model compared every cycle plus literal spot checks.
module tb_nes_loader;
    import nes_pkg::*;

    localparam int R = 4;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n, start, pause, s_valid;
    logic [15:0] base_addr, length;
    logic [7:0]  s_data;
    logic        s_ready, m_chipselect, m_write, busy, done;
    logic [15:0] m_address, m_writedata;

    nes_loader #(.RESET_CYCLES(R), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause),
        .base_addr(base_addr), .length(length), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: mode 0 idle, 1 reset, 2 load, 3 settle, 4 run; left = cycles remaining in phase.
    int          m_mode, m_left, m_idx;
    logic [15:0] m_base, m_len;
    logic [15:0] e_wdata, e_addr;
    logic        e_write, e_done;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_left = 0; m_idx = 0;
            e_write = 1'b0; e_done = 1'b0; e_addr = 16'h0; e_wdata = 16'h0200;
        end else begin
            e_write = 1'b0; e_done = 1'b0; e_addr = 16'h0;
            if ((m_mode == 0 || m_mode == 4) && start) begin
                m_mode = 1; m_left = R; m_base = base_addr; m_len = length; m_idx = 0;
            end else if (m_mode == 4 && pause) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_len != 0) m_mode = 2;
                    else begin m_mode = 3; m_left = S; end
                end
            end else if (m_mode == 2 && s_valid) begin
                e_write = 1'b1;
                e_addr  = m_base + 16'(m_idx);
                m_idx++;
                if (m_idx == int'(m_len)) begin m_mode = 3; m_left = S + 1; end
            end else if (m_mode == 3) begin
                m_left--;
                if (m_left == 0) begin m_mode = 4; e_done = 1'b1; end
            end
            case (m_mode)
                1:       e_wdata = 16'h0000;
                4:       e_wdata = 16'h0100;
                default: e_wdata = 16'h0200;
            endcase
            if (e_write) e_wdata = {8'h03, s_data};
        end
    end

    logic [15:0] beat_addr[$];
    logic [15:0] beat_data[$];
    int          done_cnt = 0;
    bit          ready_seen = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("writedata", m_writedata, e_wdata);
            chk("write", 16'(m_write), 16'(e_write));
            chk("s_ready", 16'(s_ready), 16'(m_mode == 2));
            chk("busy", 16'(busy), 16'(m_mode >= 1 && m_mode <= 3));
            chk("done", 16'(done), 16'(e_done));
            chk("chipselect", 16'(m_chipselect), 16'h1);
            if (e_write || m_mode == 4) chk("address", m_address, e_addr);
            if (m_write) begin beat_addr.push_back(m_address); beat_data.push_back(m_writedata); end
            if (done) done_cnt++;
            if (s_ready) ready_seen = 1'b1;
        end
    end

    task automatic clear_log();
        beat_addr.delete(); beat_data.delete(); done_cnt = 0; ready_seen = 1'b0;
    endtask

    task automatic chk_beat(input int i, input logic [15:0] a, input logic [15:0] d);
        if (i < beat_addr.size()) begin
            chk($sformatf("beat%0d_addr", i), beat_addr[i], a);
            chk($sformatf("beat%0d_data", i), beat_data[i], d);
        end else begin
            chk($sformatf("beat%0d_missing", i), 16'(beat_addr.size()), 16'(i + 1));
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l);
        start = 1'b1; base_addr = b; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        s_valid = 1'b1; s_data = b;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        chk("xfer_wait", 16'(n < 50), 16'h1);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        chk(name, 16'(done), 16'h1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; start = 1'b0; pause = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        base_addr = 16'h0; length = 16'h0;
        #1 reset_n = 1'b0; chk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wdata", m_writedata, 16'h0200);
            chk("rst_write", 16'(m_write), 16'h0);
            chk("rst_ready", 16'(s_ready), 16'h0);
            chk("rst_busy", 16'(busy), 16'h0);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic back-to-back load; valid is already high during RESET
        clear_log();
        do_start(16'h8000, 16'd3);
        chk("basic_reset_op", m_writedata, 16'h0000);
        send_byte(8'hA9, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        wait_done("basic_done");
        chk("basic_nbeats", 16'(beat_addr.size()), 16'd3);
        chk_beat(0, 16'h8000, 16'h03A9);
        chk_beat(1, 16'h8001, 16'h0301);
        chk_beat(2, 16'h8002, 16'h0300);
        repeat (2) @(negedge clk);
        chk("basic_run_op", m_writedata, 16'h0100);
        chk("basic_done_cnt", 16'(done_cnt), 16'd1);

        // Back-pressure: two idle cycles between bytes
        clear_log();
        do_start(16'h8000, 16'd3);
        send_byte(8'hA9, 2); send_byte(8'h01, 2); send_byte(8'h00, 0);
        wait_done("bp_done");
        chk("bp_nbeats", 16'(beat_addr.size()), 16'd3);
        chk_beat(0, 16'h8000, 16'h03A9);
        chk_beat(1, 16'h8001, 16'h0301);
        chk_beat(2, 16'h8002, 16'h0300);

        // Address wrap
        clear_log();
        do_start(16'hFFFF, 16'd2);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        wait_done("wrap_done");
        chk("wrap_nbeats", 16'(beat_addr.size()), 16'd2);
        chk_beat(0, 16'hFFFF, 16'h0311);
        chk_beat(1, 16'h0000, 16'h0322);

        // Zero length: reset then run, no bytes accepted
        clear_log();
        s_valid = 1'b1; s_data = 8'h55;
        do_start(16'h1234, 16'd0);
        wait_done("zero_done");
        s_valid = 1'b0;
        chk("zero_nbeats", 16'(beat_addr.size()), 16'd0);
        chk("zero_ready_seen", 16'(ready_seen), 16'd0);
        chk("zero_run_op", m_writedata, 16'h0100);
        chk("zero_run_addr", m_address, 16'h0000);

        // Pause in RUN
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        chk("pause_op", m_writedata, 16'h0200);
        repeat (2) @(negedge clk);

        // Back to RUN, then start+pause together: start wins
        do_start(16'h0000, 16'd0);
        wait_done("ctl_run_done");
        clear_log();
        pause = 1'b1;
        do_start(16'h4000, 16'd2);
        pause = 1'b0;
        chk("startpause_op", m_writedata, 16'h0000);
        chk("startpause_busy", 16'(busy), 16'h1);
        send_byte(8'hAA, 0);
        do_start(16'h9999, 16'd7);
        send_byte(8'hBB, 0);
        wait_done("ctl_done");
        chk("ctl_nbeats", 16'(beat_addr.size()), 16'd2);
        chk_beat(0, 16'h4000, 16'h03AA);
        chk_beat(1, 16'h4001, 16'h03BB);

        // Reset mid-load, then reload from base
        clear_log();
        do_start(16'h2000, 16'd4);
        send_byte(8'h77, 0);
        #2 reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_wdata", m_writedata, 16'h0200);
            chk("midrst_ready", 16'(s_ready), 16'h0);
            chk("midrst_busy", 16'(busy), 16'h0);
            chk("midrst_addr", m_address, 16'h0000);
        end
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        do_start(16'h2000, 16'd4);
        send_byte(8'hDE, 0); send_byte(8'hAD, 1); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        wait_done("reload_done");
        chk("reload_nbeats", 16'(beat_addr.size()), 16'd4);
        chk_beat(0, 16'h2000, 16'h03DE);
        chk_beat(1, 16'h2001, 16'h03AD);
        chk_beat(2, 16'h2002, 16'h03BE);
        chk_beat(3, 16'h2003, 16'h03EF);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
